// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline: a chain of valid-tagged stage registers with
// per-stage stall/flush, stall propagated upstream and bubbles inserted behind a frozen stage.
module ctrl_pipe #(
  parameter int WIDTH           = 14,
  parameter int STAGES          = 3,
  parameter int CLEAR_ON_BUBBLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES-1:0]         stage_held
);

  localparam bit CLR = (CLEAR_ON_BUBBLE != 0);

  logic [STAGES-1:0]             hold_s;
  logic [STAGES-1:0]             up_hold_s;
  logic [STAGES-1:0]             src_valid_s;
  logic [STAGES-1:0][WIDTH-1:0]  src_data_s;
  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q;
  logic [STAGES-1:0][WIDTH-1:0]  data_d;

  // A stage holds when it or any stage downstream of it stalls; flush plays no part.
  always_comb begin
    hold_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold_s[k] = |(stall >> k);
    end
  end

  // Per-stage load source and upstream-frozen flag; stage 0 takes the decode input.
  always_comb begin
    up_hold_s      = '0;
    src_valid_s    = '0;
    src_data_s     = '0;
    src_valid_s[0] = in_valid;
    src_data_s[0]  = (CLR && !in_valid) ? {WIDTH{1'b0}} : in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_hold_s[k]   = hold_s[k-1];
      src_valid_s[k] = valid_q[k-1];
      src_data_s[k]  = data_q[k-1];
    end
  end

  // Next-state selection in priority order: flush, hold, bubble behind frozen upstream, load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = CLR ? {WIDTH{1'b0}} : data_q[k];
      end else if (hold_s[k]) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end else if (up_hold_s[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = CLR ? {WIDTH{1'b0}} : data_q[k];
      end else begin
        valid_d[k] = src_valid_s[k];
        data_d[k]  = src_data_s[k];
      end
    end
  end

  // Stage registers; reset drops every in-flight entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready    = ~hold_s[0];
  assign stage_held  = hold_s;
  assign stage_valid = valid_q;
  assign stage_data  = data_q;

endmodule
